// File: rtl/disp_sched_pkg.sv
// Shared types and sizes for the display channel scheduler.
package disp_sched_pkg;

    localparam int CH_N  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        MANUAL = 2'd1,
        ALERT  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/disp_chan_sched_rr_pick8.sv
// Combinational search for the first set bit at or above a start index,
// wrapping from channel 7 back to channel 0.
module rr_pick8
    import disp_sched_pkg::*;
(
    input  logic [CH_N-1:0]  req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] pos_s;
    logic [SEL_W-1:0] idx_s;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        pos_s = {SEL_W{1'b0}};
        idx_s = {SEL_W{1'b0}};
        for (int i = CH_N - 1; i >= 0; i--) begin
            pos_s = start + SEL_W'(i);
            idx_s = req[pos_s] ? pos_s : idx_s;
        end
    end

    assign idx   = idx_s;
    assign found = |req;

endmodule

// File: rtl/disp_chan_sched.sv
// Channel-select scheduler for the eight-channel display multiplexer:
// alert hold beats manual switch beats automatic dwell scan.
module disp_chan_sched
    import disp_sched_pkg::*;
#(
    parameter int DWELL = 50_000_000,
    parameter int HOLD  = 100_000_000,
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_auto,
    input  logic [SEL_W-1:0] sw_sel,
    input  logic [CH_N-1:0]  ch_mask,
    input  logic [CH_N-1:0]  alert_req,
    output logic [SEL_W-1:0] test_sel,
    output logic [CH_N-1:0]  alert_ack,
    output logic             in_alert,
    output logic             sel_change
);

    localparam logic [CNT_W-1:0] DWELL_TC = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CH_N-1:0]  ACK_ONE  = {{(CH_N-1){1'b0}}, 1'b1};

    sched_state_e     state_q,      state_d;
    logic [SEL_W-1:0] test_sel_q,   test_sel_d;
    logic [CH_N-1:0]  alert_ack_q,  alert_ack_d;
    logic             in_alert_q,   in_alert_d;
    logic             sel_change_q, sel_change_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [SEL_W-1:0] rr_ptr_q,     rr_ptr_d;

    logic [SEL_W-1:0] alert_idx_s;
    logic             alert_found_s;
    logic [SEL_W-1:0] scan_start_s;
    logic [SEL_W-1:0] scan_idx_s;
    logic             scan_found_s;
    logic             hold_done_s;
    logic             arb_s;

    assign scan_start_s = test_sel_q + 3'd1;

    rr_pick8 u_alert_pick (
        .req   (alert_req),
        .start (rr_ptr_q),
        .idx   (alert_idx_s),
        .found (alert_found_s)
    );

    rr_pick8 u_scan_pick (
        .req   (ch_mask),
        .start (scan_start_s),
        .idx   (scan_idx_s),
        .found (scan_found_s)
    );

    // Arbitration happens every cycle outside a hold and on the hold's last cycle.
    assign hold_done_s = (state_q == ALERT) && (cnt_q == HOLD_TC);
    assign arb_s       = (state_q != ALERT) || hold_done_s;

    // Next-state, select and shared dwell/hold counter.
    always_comb begin
        state_d     = state_q;
        test_sel_d  = test_sel_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        alert_ack_d = {CH_N{1'b0}};
        if (arb_s && alert_found_s) begin
            state_d     = ALERT;
            test_sel_d  = alert_idx_s;
            alert_ack_d = ACK_ONE << alert_idx_s;
            rr_ptr_d    = alert_idx_s + 3'd1;
            cnt_d       = CNT_ZERO;
        end else if (state_q == ALERT) begin
            if (hold_done_s) begin
                cnt_d = CNT_ZERO;
                if (mode_auto) begin
                    state_d = SCAN;
                end else begin
                    state_d    = MANUAL;
                    test_sel_d = sw_sel;
                end
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (!mode_auto) begin
            state_d    = MANUAL;
            test_sel_d = sw_sel;
            cnt_d      = CNT_ZERO;
        end else if (state_q == MANUAL) begin
            // Scan resumes from whatever channel manual mode left selected.
            state_d = SCAN;
            cnt_d   = CNT_ZERO;
        end else if (cnt_q == DWELL_TC) begin
            cnt_d      = CNT_ZERO;
            test_sel_d = scan_found_s ? scan_idx_s : 3'd0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign in_alert_d   = (state_d == ALERT);
    assign sel_change_d = (test_sel_d != test_sel_q);

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SCAN;
            test_sel_q   <= 3'd0;
            alert_ack_q  <= {CH_N{1'b0}};
            in_alert_q   <= 1'b0;
            sel_change_q <= 1'b0;
            cnt_q        <= CNT_ZERO;
            rr_ptr_q     <= 3'd0;
        end else begin
            state_q      <= state_d;
            test_sel_q   <= test_sel_d;
            alert_ack_q  <= alert_ack_d;
            in_alert_q   <= in_alert_d;
            sel_change_q <= sel_change_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign test_sel   = test_sel_q;
    assign alert_ack  = alert_ack_q;
    assign in_alert   = in_alert_q;
    assign sel_change = sel_change_q;

endmodule
